seven_seg_scan_scheduler: RTL and testbench
===========================================

// Module: seven_seg_scan_scheduler
// PURPOSE
//  Time-multiplexes one shared 8-bit seven-segment bus across the 4 digits of the board display.
//  Owns anode sequencing, inter-digit blanking (anti-ghosting) and tear-free value updates.
//  Sits between counter/datapath blocks (producers of BCD digits) and the display pins.
// PARAMETERS
//  REFRESH_DIV   50000  clk cycles each digit is driven (SHOW time); 1 kHz/digit at 50 MHz
//  BLANK_CYCLES  500    clk cycles all anodes off before each digit; must be >= 1
// PORTS
//  clk           in   1   system clock
//  rst           in   1   asynchronous, active-low reset
//  enable        in   1   1 = scan display, 0 = IDLE (display dark)
//  load          in   1   producer offers digits_in/dp_in (valid)
//  load_ready    out  1   shadow register free; load accepted when load && load_ready
//  digits_in     in   16  4 BCD nibbles; [3:0] = digit0 (rightmost) .. [15:12] = digit3
//  dp_in         in   4   decimal point per digit, 1 = lit; bit i -> digit i
//  sevenSegment  out  8   active-low segments: [7:1] = a..g, [0] = dp
//  anode         out  4   active-low digit enables; anode[i] -> digit i
//  frame_done    out  1   1-cycle pulse at end of digit3 SHOW
// BEHAVIOUR
//  Reset (rst=0, immediate): anode=4'b1111, sevenSegment=8'hFF, frame_done=0, load_ready=1,
//   active digits=16'hFFFF (blank), active dp=0, shadow empty, idx=0, state IDLE, counter=0.
//  FSM: IDLE -> BLANK (enable=1); BLANK -> SHOW after BLANK_CYCLES; SHOW -> BLANK after
//   REFRESH_DIV with idx=idx+1 (3 wraps to 0). Any state -> IDLE next cycle when enable=0.
//  IDLE/BLANK: anode=4'b1111, sevenSegment=8'hFF. SHOW: anode has only bit idx low,
//   sevenSegment = decode(active nibble idx) with bit0 = ~dp[idx]; registered outputs.
//  Frame period = 4*(REFRESH_DIV+BLANK_CYCLES) cycles; first SHOW after enable starts at digit0.
//  Decode: 0-9 standard glyphs (0=8'b0000001x .. 9=8'b0000100x); codes 10-15 blank (a..g off).
//  Handshake: accepted load copies digits_in/dp_in into shadow, sets pending, load_ready=0
//   from next cycle. Load while pending: ignored (producer must hold load until ready).
//  Transfer shadow -> active: on the cycle frame_done pulses (end of digit3 SHOW), or on any
//   IDLE cycle. pending clears same cycle; load_ready=1 the following cycle. A frame never
//   mixes old and new values.
//  Load and transfer in the same cycle: load_ready is 0, load not accepted.
//  enable drop mid-frame: counter and idx cleared, frame_done not pulsed, pending shadow is
//   transferred in IDLE.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: nibble==0 on digit3, digit3..2, or digit3..1 (leading run)
//   decodes blank (dp still honoured); digit0 always shown.
//  Not defined: every nibble 0 renders glyph '0'.
// STRUCTURE
//  Package seg7_pkg: state enum {IDLE,BLANK,SHOW}, SEG_BLANK=8'hFF, ANODE_OFF=4'b1111, glyph table.
//  Sub-module seg7_decode (4-bit code -> 7 active-low segments, combinational); one instance.
//  Top holds FSM, 32-bit phase counter, idx, shadow/active registers, leading-zero mask.
// TESTING (REFRESH_DIV=8, BLANK_CYCLES=2)
//  Assert rst=0 mid-SHOW, no clk edge -> anode=1111, sevenSegment=FF, load_ready=1 immediately.
//  enable=0, load 16'h1234 -> transferred in IDLE; enable=1 -> 2 blank cycles then anode=1110,
//   sevenSegment=8'b10011001 for 8 cycles; frame_done pulses every 40 cycles.
//  Load 16'h5678 during digit1 SHOW -> digits2/3 still show 2/1; next frame digit0=8;
//   load_ready=0 until cycle after frame_done.
//  Second load while pending -> ignored; after transfer, active still holds first value.
//  digits_in=16'h00A0, dp_in=4'b0010 -> digit1 sevenSegment=8'b11111110; toggle enable=0 for
//   1 cycle mid-frame -> restart at digit0, no frame_done.
//  16'h0070 with LEADING_ZERO_BLANK_EN -> digit3/2 = FF, digit1 = 7 glyph, digit0 = '0';
//   without macro digit3/2 show '0'.

Source files
------------

// File: rtl/seven_seg_scan_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_scheduler_pkg
// Shared types and constants for the four-digit seven-segment scan scheduler.
//   scan_state_t : scan FSM states (IDLE, BLANK, SHOW)
//   SEG_BLANK    : segment bus value with every segment and dp dark (active-low)
//   ANODE_OFF    : all digit enables off (active-low)
//   GLYPH_TABLE  : BCD code -> active-low segments a..g (bit 6 = a, bit 0 = g);
//                  codes 10-15 render blank
//   anode_for()  : active-low one-hot digit enable for a digit index
// -----------------------------------------------------------------------------
package seven_seg_scan_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam logic [7:0] SEG_BLANK   = 8'hFF;
    localparam logic [3:0] ANODE_OFF   = 4'b1111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK,
        GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK
    };

    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seven_seg_scan_scheduler_if.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_scheduler_if
// Bundles the producer handshake and the display pins of the scan scheduler.
//   enable       : 1 = scan the display, 0 = dark / idle
//   load         : producer offers digits_in / dp_in
//   load_ready   : shadow register free; load taken when load && load_ready
//   digits_in    : four BCD nibbles, [3:0] = digit0 (rightmost)
//   dp_in        : decimal point per digit, 1 = lit
//   sevenSegment : active-low segments, [7:1] = a..g, [0] = dp
//   anode        : active-low digit enables, anode[i] -> digit i
//   frame_done   : one-cycle pulse in the last SHOW cycle of digit3
// master = producer / board side, slave = scheduler.
// -----------------------------------------------------------------------------
interface seven_seg_scan_scheduler_if;
    logic        enable;
    logic        load;
    logic        load_ready;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [7:0]  sevenSegment;
    logic [3:0]  anode;
    logic        frame_done;

    modport master (
        output enable, load, digits_in, dp_in,
        input  load_ready, sevenSegment, anode, frame_done
    );

    modport slave (
        input  enable, load, digits_in, dp_in,
        output load_ready, sevenSegment, anode, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_scheduler_decode.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_scheduler_decode
// Combinational BCD to seven-segment decoder (active-low, a..g).
//   i_code : 4-bit code; 0-9 give digit glyphs, 10-15 give a blank digit
//   o_seg  : segments a..g, bit 6 = a
// -----------------------------------------------------------------------------
module seven_seg_scan_scheduler_decode
    import seven_seg_scan_scheduler_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    assign o_seg = GLYPH_TABLE[i_code];

endmodule

// File: rtl/seven_seg_scan_scheduler.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_scheduler
// Time-multiplexes one shared segment bus across four digits. Each digit is
// preceded by BLANK_CYCLES with all anodes off (anti-ghosting) and then driven
// for REFRESH_DIV cycles. New values enter a shadow register and are copied to
// the displayed (active) register only at a frame boundary or while idle, so a
// frame never mixes old and new digits.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   bus  : seven_seg_scan_scheduler_if.slave (handshake + display pins)
// Parameters:
//   REFRESH_DIV  : SHOW cycles per digit
//   BLANK_CYCLES : dark cycles before each digit, must be >= 1
// Build option:
//   LEADING_ZERO_BLANK_EN : when defined, a leading run of zero digits
//   (digit3, digit3..2, digit3..1) is blanked; digit0 always shows and decimal
//   points are still honoured.
// -----------------------------------------------------------------------------
module seven_seg_scan_scheduler
    import seven_seg_scan_scheduler_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                     clk,
    input  logic                     rst,
    seven_seg_scan_scheduler_if.slave bus
);

    localparam logic [31:0] SHOW_LAST  = 32'(REFRESH_DIV - 1);
    localparam logic [31:0] BLANK_LAST = 32'(BLANK_CYCLES - 1);

    scan_state_t r_state;
    scan_state_t w_state_next;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_next;
    logic [1:0]  r_idx;
    logic [1:0]  w_idx_next;
    logic        w_frame_end;

    logic [15:0] r_shadow_digits;
    logic [3:0]  r_shadow_dp;
    logic        r_pending;
    logic [15:0] r_active_digits;
    logic [3:0]  r_active_dp;

    logic        w_load_accept;
    logic        w_transfer;

    logic [3:0]  r_anode;
    logic [7:0]  r_seg;
    logic [3:0]  w_anode_next;
    logic [7:0]  w_seg_next;
    logic [3:0]  w_lz_blank;
    logic [3:0]  w_code;
    logic [6:0]  w_glyph;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_frame_end  = 1'b0;
        if (!bus.enable) begin
            // Dropping enable always restarts the next scan from digit0.
            w_state_next = IDLE;
            w_cnt_next   = '0;
            w_idx_next   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next = BLANK;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                end
                BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state_next = SHOW;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 32'd1;
                    end
                end
                SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        w_state_next = BLANK;
                        w_cnt_next   = '0;
                        w_idx_next   = r_idx + 2'd1;
                        w_frame_end  = (r_idx == 2'd3);
                    end else begin
                        w_cnt_next = r_cnt + 32'd1;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------- handshake / transfer
    // A transfer only ever happens with pending set, and a load is only taken
    // with pending clear, so the two can never coincide.
    assign w_load_accept = bus.load && !r_pending;
    assign w_transfer    = r_pending && (w_frame_end || (r_state == IDLE));

    // ------------------------------------------------ leading-zero blanking
`ifdef LEADING_ZERO_BLANK_EN
    logic [3:1] w_nib_zero;
    genvar gi;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_nib_zero
            assign w_nib_zero[gi] = (r_active_digits[gi*4 +: 4] == 4'd0);
        end
    endgenerate
    // Blank a digit only when it and every more-significant digit are zero.
    assign w_lz_blank = {w_nib_zero[3], &w_nib_zero[3:2], &w_nib_zero[3:1], 1'b0};
`else
    assign w_lz_blank = 4'b0000;
`endif

    // ------------------------------------------------------ output datapath
    // Outputs are computed from the next state/index so the registered pins
    // line up exactly with the state register.
    assign w_code = w_lz_blank[w_idx_next] ? 4'hF
                                           : r_active_digits[{w_idx_next, 2'b00} +: 4];

    seven_seg_scan_scheduler_decode u_decode (
        .i_code (w_code),
        .o_seg  (w_glyph)
    );

    assign w_seg_next   = (w_state_next == SHOW) ? {w_glyph, ~r_active_dp[w_idx_next]}
                                                 : SEG_BLANK;
    assign w_anode_next = (w_state_next == SHOW) ? anode_for(w_idx_next) : ANODE_OFF;

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_idx           <= '0;
            r_anode         <= ANODE_OFF;
            r_seg           <= SEG_BLANK;
            r_pending       <= 1'b0;
            r_shadow_digits <= 16'hFFFF;
            r_shadow_dp     <= 4'b0000;
            r_active_digits <= 16'hFFFF;
            r_active_dp     <= 4'b0000;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_anode <= w_anode_next;
            r_seg   <= w_seg_next;

            if (w_load_accept) begin
                r_shadow_digits <= bus.digits_in;
                r_shadow_dp     <= bus.dp_in;
            end

            if (w_transfer) begin
                r_active_digits <= r_shadow_digits;
                r_active_dp     <= r_shadow_dp;
            end

            if (w_transfer) begin
                r_pending <= 1'b0;
            end else if (w_load_accept) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign bus.load_ready   = ~r_pending;
    assign bus.frame_done   = w_frame_end;
    assign bus.anode        = r_anode;
    assign bus.sevenSegment = r_seg;

endmodule

// File: tb/tb_seven_seg_scan_scheduler.sv
module tb_seven_seg_scan_scheduler;

    localparam int R     = 8;
    localparam int B     = 2;
    localparam int SLOT  = R + B;
    localparam int FRAME = 4 * SLOT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scan_scheduler_if bus ();

    seven_seg_scan_scheduler #(
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit model_on = 1'b0;
    bit mon_on   = 1'b0;

    // scoreboard queues: show windows {anode, seg, length}, frame_done cycles,
    // load_ready changes (cycle, new value)
    logic [19:0] win_q[$];
    int          fd_q[$];
    int          lr_cyc_q[$];
    logic        lr_val_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic record_fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // segments lit (active-high) in order a,b,c,d,e,f,g
    function automatic logic [6:0] lit_abcdefg(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] dp, input int d);
        logic [3:0] nib;
        bit         blank;
        nib   = 4'((v >> (4 * d)) & 16'h000F);
        blank = (nib > 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (v >> (4 * d)) == 16'h0000) blank = 1'b1;
`endif
        return {(blank ? 7'h7F : ~lit_abcdefg(nib)), ~dp[d]};
    endfunction

    // ------------------------------------------------ reference model
    // Scan position = cycles since the scan started, modulo one frame; each
    // slot is B dark cycles followed by R lit cycles.
    initial begin : model
        int pos, npos, len, prev_d, new_d;
        bit prev_show, new_show, fd_prev, xfer, acc, pend, npend;
        logic [15:0] act, shd;
        logic [3:0]  act_dp, shd_dp, w_an;
        logic [7:0]  w_sg;
        bit          s_en, s_load;
        logic [15:0] s_dig;
        logic [3:0]  s_dp;
        wait (model_on);
        pos = -1; len = 0; pend = 1'b0;
        act = 16'hFFFF; act_dp = 4'b0; shd = 16'hFFFF; shd_dp = 4'b0;
        w_an = 4'hF; w_sg = 8'hFF;
        s_en = bus.enable; s_load = bus.load; s_dig = bus.digits_in; s_dp = bus.dp_in;
        while (model_on) begin
            @(posedge clk);
            #2;
            fd_prev = s_en && (pos == FRAME - 1);
            xfer    = pend && (pos < 0 || fd_prev);
            acc     = s_load && !pend;
            if (!s_en)        npos = -1;
            else if (pos < 0) npos = 0;
            else              npos = (pos + 1) % FRAME;
            prev_show = (pos >= 0) && ((pos % SLOT) >= B);
            prev_d    = (pos >= 0) ? pos / SLOT : 0;
            new_show  = (npos >= 0) && ((npos % SLOT) >= B);
            new_d     = (npos >= 0) ? npos / SLOT : 0;
            if (prev_show && !(new_show && new_d == prev_d))
                win_q.push_back({w_an, w_sg, len[7:0]});
            if (new_show && !(prev_show && new_d == prev_d)) begin
                w_an = ~(4'b0001 << new_d);
                w_sg = exp_seg(act, act_dp, new_d);
                len  = 1;
            end else if (new_show) begin
                len++;
            end
            pos   = npos;
            npend = pend;
            if (xfer) begin
                act = shd; act_dp = shd_dp; npend = 1'b0;
            end else if (acc) begin
                shd = s_dig; shd_dp = s_dp; npend = 1'b1;
            end
            if (npend != pend) begin
                lr_cyc_q.push_back(cyc);
                lr_val_q.push_back(!npend);
            end
            pend = npend;
            s_en = bus.enable; s_load = bus.load; s_dig = bus.digits_in; s_dp = bus.dp_in;
            if (s_en && pos == FRAME - 1) fd_q.push_back(cyc);
        end
    end

    // ------------------------------------------------ monitor
    initial begin : monitor
        bit          open_w, exp_fd, exp_lr;
        logic [3:0]  an;
        logic [7:0]  sg;
        int          len;
        logic        lr_prev;
        logic [19:0] e;
        open_w = 1'b0; lr_prev = 1'b1; len = 0; an = 4'hF; sg = 8'hFF;
        wait (mon_on);
        forever begin
            @(negedge clk);
            if (!mon_on) break;
            exp_fd = (fd_q.size() > 0) && (fd_q[0] == cyc);
            if (bus.frame_done || exp_fd) begin
                check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
                if (exp_fd) void'(fd_q.pop_front());
            end
            exp_lr = (lr_cyc_q.size() > 0) && (lr_cyc_q[0] == cyc);
            if ((bus.load_ready !== lr_prev) || exp_lr) begin
                check("load_ready", 32'(bus.load_ready), 32'(exp_lr ? lr_val_q[0] : lr_prev));
                if (exp_lr) begin
                    void'(lr_cyc_q.pop_front());
                    void'(lr_val_q.pop_front());
                end
                lr_prev = bus.load_ready;
            end
            if (open_w) begin
                if (bus.anode == an && bus.sevenSegment == sg) begin
                    len++;
                end else begin
                    open_w = 1'b0;
                    if (win_q.size() == 0) begin
                        record_fail("show_window unexpected", {12'h0, an, sg, len[7:0]}, 32'h0);
                    end else begin
                        e = win_q.pop_front();
                        check("show_window {anode,seg,len}", {12'h0, an, sg, len[7:0]}, {12'h0, e});
                    end
                end
            end
            if (!open_w && bus.anode != 4'hF) begin
                open_w = 1'b1;
                an     = bus.anode;
                sg     = bus.sevenSegment;
                len    = 1;
            end
        end
    end

    // ------------------------------------------------ stimulus helpers
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) sync();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
        bit ok;
        sync();
        bus.load = 1'b1; bus.digits_in = d; bus.dp_in = dp;
        ok = 1'b0;
        for (int k = 0; k < 4 * FRAME; k++) begin
            @(negedge clk);
            if (bus.load_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) record_fail("load accept timeout", 32'(bus.load_ready), 32'h1);
        sync();
        bus.load = 1'b0;
        $display("load digits=%h dp=%b accepted=%0d cycle=%0d", d, dp, ok, cyc);
    endtask

    task automatic wait_anode(input logic [3:0] target);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge clk);
            if (bus.anode == target) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) record_fail("wait_anode timeout", 32'(bus.anode), 32'(target));
    endtask

    // ------------------------------------------------ main sequence
    initial begin : stim
        logic [15:0] d;
        logic [7:0]  exp3;
        bus.enable = 1'b0; bus.load = 1'b0; bus.digits_in = 16'h0; bus.dp_in = 4'h0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset anode", 32'(bus.anode), 32'hF);
        check("reset sevenSegment", 32'(bus.sevenSegment), 32'hFF);
        check("reset load_ready", 32'(bus.load_ready), 32'h1);
        check("reset frame_done", 32'(bus.frame_done), 32'h0);
        rst = 1'b1;
        model_on = 1'b1;
        mon_on   = 1'b1;

        // load while idle is transferred immediately, then start scanning
        tick(2);
        do_load(16'h1234, 4'b0000);
        tick(3);
        bus.enable = 1'b1;
        wait_anode(4'b1110);
        check("first digit0 glyph 4", 32'(bus.sevenSegment), 32'h99);

        // load during digit1, then a second load while pending (ignored)
        wait_anode(4'b1101);
        do_load(16'h5678, 4'b0000);
        sync();
        bus.load = 1'b1; bus.digits_in = 16'h9999; bus.dp_in = 4'b1111;
        sync();
        bus.load = 1'b0;
        tick(FRAME + 2);
        wait_anode(4'b1110);
        check("digit0 after transfer is 8", 32'(bus.sevenSegment), 32'h01);
        check("load_ready after transfer", 32'(bus.load_ready), 32'h1);

        // blank code with dp lit, then a one-cycle enable drop mid-frame
        do_load(16'h00A0, 4'b0010);
        tick(FRAME + 2);
        wait_anode(4'b1101);
        check("digit1 code A with dp", 32'(bus.sevenSegment), 32'hFE);
        wait_anode(4'b1011);
        sync();
        bus.enable = 1'b0;
        sync();
        bus.enable = 1'b1;
        tick(FRAME);

        // leading-zero behaviour
        do_load(16'h0070, 4'b0000);
        tick(FRAME + 2);
        wait_anode(4'b0111);
`ifdef LEADING_ZERO_BLANK_EN
        exp3 = 8'hFF;
`else
        exp3 = 8'h03;
`endif
        check("digit3 of 0070", 32'(bus.sevenSegment), 32'(exp3));

        // randomized loads, waits and enable drops
        for (int k = 0; k < 25; k++) begin
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 1) == 0 && j >= 1) d[j*4 +: 4] = 4'h0;
                else d[j*4 +: 4] = 4'($urandom_range(0, 15));
            end
            do_load(d, 4'($urandom_range(0, 15)));
            tick($urandom_range(0, 60));
            if ($urandom_range(0, 4) == 0) begin
                bus.enable = 1'b0;
                tick($urandom_range(1, 3));
                bus.enable = 1'b1;
            end
        end

        bus.enable = 1'b0;
        tick(6);
        mon_on   = 1'b0;
        model_on = 1'b0;
        tick(2);
        check("show windows all matched", 32'(win_q.size()), 32'h0);
        check("frame_done all seen", 32'(fd_q.size()), 32'h0);
        check("load_ready changes all seen", 32'(lr_cyc_q.size()), 32'h0);

        // asynchronous reset in the middle of a SHOW with a load pending
        bus.enable = 1'b1;
        wait_anode(4'b1110);
        sync();
        bus.load = 1'b1; bus.digits_in = 16'h4321; bus.dp_in = 4'b0;
        sync();
        bus.load = 1'b0;
        @(negedge clk);
        check("load_ready low while pending", 32'(bus.load_ready), 32'h0);
        check("still showing digit0", 32'(bus.anode), 32'hE);
        #1;
        rst = 1'b0;
        #1;
        check("async reset anode", 32'(bus.anode), 32'hF);
        check("async reset sevenSegment", 32'(bus.sevenSegment), 32'hFF);
        check("async reset load_ready", 32'(bus.load_ready), 32'h1);
        check("async reset frame_done", 32'(bus.frame_done), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
